// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI serial receiver: FSM encoding and bit-rate defaults.
package midi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int unsigned MIDI_BAUD        = 31250;
    // 50 MHz system clock / 31250 baud
    localparam int unsigned CLKS_PER_BIT_DEF = 1600;

endpackage

// File: rtl/shift_reg.sv
// Generic W-bit serial-in shift register with synchronous clear and clock enable.
module shift_reg #(
    parameter int unsigned W   = 8,
    parameter bit          DIR = 1'b1  // 1: shift right (new bit enters at MSB)
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_ce,
    input  logic         i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_ce) begin
            if (DIR) begin
                r_q <= {i_d, r_q[W-1:1]};
            end else begin
                r_q <= {r_q[W-2:0], i_d};
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronises RX, samples mid-bit, and strobes each framed byte to the parser.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1, r_rx_s, r_rx_d;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bitn, w_bitn_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             w_ce;
    logic [7:0]       w_q;

    shift_reg #(
        .W   (8),
        .DIR (1'b1)
    ) u_shift_reg (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_ce  (w_ce),
        .i_d   (r_rx_s),
        .o_q   (w_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bitn  <= w_bitn_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bitn_nxt  = r_bitn;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_ce        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Edge, not level: a line stuck low cannot re-trigger
                if (r_rx_d && !r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_bitn_nxt  = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_ce       = 1'b1;
                    w_cnt_nxt  = '0;
                    w_bitn_nxt = r_bitn + 1'b1;
                    if (r_bitn == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_rx_s) begin
                        w_data_nxt  = w_q;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: directed scenarios then random frames against a frame-level model.
module tb_midi_uart_rx;

    localparam int CPB = 16;
    localparam int LAT_LO = CPB / 2 + 9 * CPB + 2 - 1;
    localparam int LAT_HI = CPB / 2 + 9 * CPB + 2 + 2;

    typedef struct {
        int         cyc;
        logic       v;
        logic       fe;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_busy;

    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] model_data = 8'h00;
    ev_t        evq[$];
    logic       prev_strobe = 1'b0;

    midi_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        n_assert++;
        assert (v >= lo && v <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    // Strobe monitor: logs every event and checks exclusivity / spacing
    always @(negedge clk) begin
        if (o_valid || o_frame_err) begin
            evq.push_back('{cyc: cyc, v: o_valid, fe: o_frame_err, d: o_data});
            check("strobe_exclusive", {31'b0, o_valid & o_frame_err}, 32'd0);
            check("strobe_not_consecutive", {31'b0, prev_strobe}, 32'd0);
        end
        prev_strobe = o_valid | o_frame_err;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
        fall = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    // Frame-level model: good stop -> VALID with the byte; bad stop -> FRAME_ERR, data held
    task automatic expect_frame(input string tag, input int fall, input logic [7:0] b,
                                input logic stop, output int ecyc);
        ev_t e;
        ecyc = -1;
        check({tag, "_events"}, evq.size(), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            ecyc = e.cyc;
            if (stop) model_data = b;
            check({tag, "_valid"}, {31'b0, e.v}, {31'b0, stop});
            check({tag, "_ferr"}, {31'b0, e.fe}, {31'b0, ~stop});
            check({tag, "_data"}, {24'b0, e.d}, {24'b0, model_data});
            check_range({tag, "_latency"}, e.cyc - fall, LAT_LO, LAT_HI);
        end
        evq.delete();
    endtask

    initial begin
        int fall, e1, e2, busy_cnt, gap;
        logic [7:0] rb;
        logic rstop, prev_bad;

        repeat (3) @(negedge clk);
        check("reset_data", {24'b0, o_data}, 32'd0);
        check("reset_valid", {31'b0, o_valid}, 32'd0);
        check("reset_ferr", {31'b0, o_frame_err}, 32'd0);
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        rst = 1'b0;
        idle_bits(2);

        send_frame(8'h90, 1'b1, fall);
        expect_frame("f90", fall, 8'h90, 1'b1, e1);
        check("f90_busy_after", {31'b0, o_busy}, 32'd0);
        idle_bits(1);

        send_frame(8'h3C, 1'b1, fall);
        expect_frame("f3c", fall, 8'h3C, 1'b1, e1);
        send_frame(8'h7F, 1'b1, fall);
        expect_frame("f7f", fall, 8'h7F, 1'b1, e2);
        check("b2b_spacing", e2 - e1, 32'd160);
        idle_bits(1);

        send_frame(8'h55, 1'b0, fall);
        expect_frame("f55_bad_stop", fall, 8'h55, 1'b0, e1);
        idle_bits(1);
        check("f55_data_held", {24'b0, o_data}, 32'h7F);

        // Short low glitch must be rejected at the mid-start sample
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            busy_cnt += int'(o_busy);
        end
        check_range("glitch_busy_cycles", busy_cnt, 1, 9);
        check("glitch_events", evq.size(), 32'd0);
        check("glitch_idle", {31'b0, o_busy}, 32'd0);
        send_frame(8'hF8, 1'b1, fall);
        expect_frame("ff8", fall, 8'hF8, 1'b1, e1);
        idle_bits(1);

        // Reset mid bit 3 of 0xF9; remaining bits are all 1 so no false edge follows
        rb = 8'hF9;
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(rb[i]);
        rx = rb[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        check("rst_data", {24'b0, o_data}, {24'b0, model_data});
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_ferr", {31'b0, o_frame_err}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 4; i < 8; i++) bit_time(rb[i]);
        bit_time(1'b1);
        idle_bits(1);
        check("rst_no_strobe", evq.size(), 32'd0);
        send_frame(8'h45, 1'b1, fall);
        expect_frame("f45", fall, 8'h45, 1'b1, e1);
        idle_bits(1);

        // Break: one FRAME_ERR, then silence while the line stays low
        fall = cyc;
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        expect_frame("break", fall, 8'h00, 1'b0, e1);
        idle_bits(2);
        check("break_no_retrigger", evq.size(), 32'd0);
        send_frame(8'hA0, 1'b1, fall);
        expect_frame("fa0", fall, 8'hA0, 1'b1, e1);

        // Random frames; a bad stop needs idle before the next start edge
        prev_bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            gap = prev_bad ? 1 + int'($urandom_range(2)) : int'($urandom_range(2));
            if (gap > 0) idle_bits(gap);
            rb = 8'($urandom);
            rstop = ($urandom_range(3) != 0);
            send_frame(rb, rstop, fall);
            expect_frame("rand", fall, rb, rstop, e1);
            prev_bad = ~rstop;
        end
        idle_bits(1);
        check("final_data", {24'b0, o_data}, {24'b0, model_data});
        check("final_busy", {31'b0, o_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
